// File: rtl/write_req_fifo_pkg.sv
// Shared definitions for the write-request FIFO: default field widths of a
// write request, the packed request layout and a width helper.
package write_req_fifo_pkg;

    localparam int unsigned WREQ_ROW_PARA   = 4;
    localparam int unsigned WREQ_ADDR_WIDTH = 48;
    localparam int unsigned WREQ_DATA_WIDTH = 256;

    // Field order is bank_en, addr, data (MSB to LSB once packed).
    typedef struct packed {
        logic [WREQ_ROW_PARA-1:0]   bank_en;
        logic [WREQ_ADDR_WIDTH-1:0] addr;
        logic [WREQ_DATA_WIDTH-1:0] data;
    } wreq_t;

    // Total width of one stored request for arbitrary field widths.
    function automatic int unsigned wreq_width(int unsigned row_para,
                                               int unsigned addr_width,
                                               int unsigned data_width);
        return row_para + addr_width + data_width;
    endfunction

endpackage

// File: rtl/write_req_fifo_if.sv
// Producer-side and arbiter-side handshake bundle of the write-request FIFO.
// 'slave' is the FIFO view, 'master' is the view of the surrounding logic
// (producer and write arbiter) that drives the FIFO.
interface write_req_fifo_if #(
    parameter int unsigned ROW_PARA   = write_req_fifo_pkg::WREQ_ROW_PARA,
    parameter int unsigned ADDR_WIDTH = write_req_fifo_pkg::WREQ_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = write_req_fifo_pkg::WREQ_DATA_WIDTH
) ();
    import write_req_fifo_pkg::*;

    // Producer side
    logic                  in_valid_i;
    logic [ROW_PARA-1:0]   in_bank_en_i;
    logic [ADDR_WIDTH-1:0] in_addr_i;
    logic [DATA_WIDTH-1:0] in_data_i;
    logic                  in_ready_o;

    // Arbiter side
    logic                  out_valid_o;
    logic [ROW_PARA-1:0]   out_bank_en_o;
    logic [ADDR_WIDTH-1:0] out_addr_o;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic                  out_ready_i;

    modport slave (
        input  in_valid_i,
        input  in_bank_en_i,
        input  in_addr_i,
        input  in_data_i,
        output in_ready_o,
        output out_valid_o,
        output out_bank_en_o,
        output out_addr_o,
        output out_data_o,
        input  out_ready_i
    );

    modport master (
        output in_valid_i,
        output in_bank_en_i,
        output in_addr_i,
        output in_data_i,
        input  in_ready_o,
        input  out_valid_o,
        input  out_bank_en_o,
        input  out_addr_o,
        input  out_data_o,
        output out_ready_i
    );

endinterface

// File: rtl/write_req_fifo_wreq_ram.sv
// Request storage for the write-request FIFO: DEPTH words of WIDTH bits,
// synchronous write, asynchronous (combinational) read so the head entry is
// visible in the same cycle its read pointer selects it.
module wreq_ram #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 308
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store one request per enabled cycle; contents need no reset since the
    // FIFO masks the head whenever it is empty.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/write_req_fifo.sv
// Show-ahead FIFO buffering write requests between a producer and a write
// arbiter. Pointer and occupancy control live here; storage is wreq_ram.
// Optional macro WRITE_REQ_FIFO_STATS_EN adds max_count_o, a high-water mark
// of the occupancy.
module write_req_fifo #(
    parameter int unsigned ROW_PARA     = write_req_fifo_pkg::WREQ_ROW_PARA,
    parameter int unsigned ADDR_WIDTH   = write_req_fifo_pkg::WREQ_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH   = write_req_fifo_pkg::WREQ_DATA_WIDTH,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned AFULL_THRESH = 6
) (
    input  logic                   clk,
    input  logic                   rst_p,
    write_req_fifo_if.slave        bus,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   almost_full_o
`ifdef WRITE_REQ_FIFO_STATS_EN
    ,
    output logic [$clog2(DEPTH):0] max_count_o
`endif
);
    import write_req_fifo_pkg::*;

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned ReqW = wreq_width(ROW_PARA, ADDR_WIDTH, DATA_WIDTH);

    typedef struct packed {
        logic [ROW_PARA-1:0]   bank_en;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    // Elaboration-time parameter sanity checks.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("write_req_fifo: DEPTH must be a power of two >= 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("write_req_fifo: AFULL_THRESH must be in 1..DEPTH");
    end

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            in_ready;
    logic            out_valid;
    logic            push;
    logic            pop;
    logic            ram_we;
    req_t            wr_req;
    req_t            rd_req;
    logic [ReqW-1:0] rd_word;

    // Handshake qualifiers; ready depends only on registered occupancy.
    always_comb begin
        in_ready  = (count_q != CntW'(DEPTH));
        out_valid = (count_q != '0);
        push      = bus.in_valid_i && in_ready;
        pop       = out_valid && bus.out_ready_i;
        // The reset cycle must not leave a stale write behind in storage.
        ram_we    = push && !rst_p;
        wr_req    = '{bank_en: bus.in_bank_en_i,
                      addr:    bus.in_addr_i,
                      data:    bus.in_data_i};
    end

    // Next-state pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    wreq_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ReqW)
    ) u_wreq_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (wr_req),
        .raddr (rd_ptr_q),
        .rdata (rd_word)
    );

    assign rd_req = req_t'(rd_word);

    // Head presentation; fields are forced to zero when empty so the arbiter
    // never sees stale bank enables.
    always_comb begin
        bus.in_ready_o    = in_ready;
        bus.out_valid_o   = out_valid;
        bus.out_bank_en_o = out_valid ? rd_req.bank_en : '0;
        bus.out_addr_o    = out_valid ? rd_req.addr    : '0;
        bus.out_data_o    = out_valid ? rd_req.data    : '0;
        count_o           = count_q;
        almost_full_o     = (count_q >= CntW'(AFULL_THRESH));
    end

`ifdef WRITE_REQ_FIFO_STATS_EN
    logic [CntW-1:0] max_count_q;

    // High-water mark follows the next occupancy so it never lags count_o.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            max_count_q <= '0;
        end else if (count_d > max_count_q) begin
            max_count_q <= count_d;
        end
    end

    assign max_count_o = max_count_q;
`endif

endmodule

// File: tb/tb_write_req_fifo.sv
// Directed bench for write_req_fifo with default parameters.
module tb_write_req_fifo;
    import write_req_fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst_p;
    logic [3:0] count;
    logic       afull;
`ifdef WRITE_REQ_FIFO_STATS_EN
    logic [3:0] max_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    write_req_fifo_if wif ();

    write_req_fifo dut (
        .clk           (clk),
        .rst_p         (rst_p),
        .bus           (wif),
        .count_o       (count),
        .almost_full_o (afull)
`ifdef WRITE_REQ_FIFO_STATS_EN
        ,
        .max_count_o   (max_count)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wif.in_valid_i   = 1'b0;
        wif.in_bank_en_i = '0;
        wif.in_addr_i    = '0;
        wif.in_data_i    = '0;
        wif.out_ready_i  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_p = 1'b1;
        step();
        rst_p = 1'b0;
        vectors++;
        if (wif.in_ready_o !== 1'b1) begin
            $display("FAIL reset_in_ready: got %b want 1", wif.in_ready_o); miscompares++;
        end
        vectors++;
        if (wif.out_valid_o !== 1'b0) begin
            $display("FAIL reset_out_valid: got %b want 0", wif.out_valid_o); miscompares++;
        end
        vectors++;
        if (count !== 4'd0) begin
            $display("FAIL reset_count: got %0d want 0", count); miscompares++;
        end
        vectors++;
        if (afull !== 1'b0) begin
            $display("FAIL reset_afull: got %b want 0", afull); miscompares++;
        end
        vectors++;
        if (wif.out_data_o !== 256'd0 || wif.out_addr_o !== 48'd0) begin
            $display("FAIL reset_out_fields: got addr %0h data %0h want 0",
                     wif.out_addr_o, wif.out_data_o); miscompares++;
        end
    endtask

    task automatic test_single_push();
        wreq_t exp;
        exp = '{bank_en: 4'b0001, addr: 48'h10, data: 256'hAA};
        wif.in_valid_i   = 1'b1;
        wif.in_bank_en_i = 4'b0001;
        wif.in_addr_i    = 48'h10;
        wif.in_data_i    = 256'hAA;
        wif.out_ready_i  = 1'b0;
        step();
        idle_inputs();
        vectors++;
        if (wif.out_valid_o !== 1'b1) begin
            $display("FAIL single_out_valid: got %b want 1", wif.out_valid_o); miscompares++;
        end
        vectors++;
        if (wif.out_addr_o !== 48'h10) begin
            $display("FAIL single_addr: got %0h want 10", wif.out_addr_o); miscompares++;
        end
        vectors++;
        if (count !== 4'd1) begin
            $display("FAIL single_count: got %0d want 1", count); miscompares++;
        end
        vectors++;
        if ({wif.out_bank_en_o, wif.out_addr_o, wif.out_data_o} !== exp) begin
            $display("FAIL single_struct: got be %b data %0h want be 0001 data aa",
                     wif.out_bank_en_o, wif.out_data_o); miscompares++;
        end
        wif.out_ready_i = 1'b1;
        step();
        wif.out_ready_i = 1'b0;
        vectors++;
        if (count !== 4'd0 || wif.out_valid_o !== 1'b0) begin
            $display("FAIL single_drain: got count %0d valid %b want 0 0",
                     count, wif.out_valid_o); miscompares++;
        end
        vectors++;
        if (wif.out_bank_en_o !== 4'd0 || wif.out_addr_o !== 48'd0) begin
            $display("FAIL empty_zero_fields: got be %b addr %0h want 0 0",
                     wif.out_bank_en_o, wif.out_addr_o); miscompares++;
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            wif.in_valid_i   = 1'b1;
            wif.in_bank_en_i = 4'(i);
            wif.in_addr_i    = 48'h100 + 48'(i);
            wif.in_data_i    = 256'(i);
            step();
            vectors++;
            if (count !== 4'(i + 1)) begin
                $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1);
                miscompares++;
            end
            vectors++;
            if (afull !== ((i + 1) >= 6)) begin
                $display("FAIL fill_afull[%0d]: got %b want %b", i, afull, (i + 1) >= 6);
                miscompares++;
            end
        end
        vectors++;
        if (wif.in_ready_o !== 1'b0) begin
            $display("FAIL full_in_ready: got %b want 0", wif.in_ready_o); miscompares++;
        end
        vectors++;
        if (wif.out_addr_o !== 48'h100) begin
            $display("FAIL full_head: got %0h want 100", wif.out_addr_o); miscompares++;
        end
        wif.in_addr_i = 48'h999;
        step();
        vectors++;
        if (count !== 4'd8 || wif.in_ready_o !== 1'b0) begin
            $display("FAIL ninth_rejected: got count %0d ready %b want 8 0",
                     count, wif.in_ready_o); miscompares++;
        end
    endtask

    task automatic test_full_pop();
        wif.in_valid_i  = 1'b1;
        wif.in_addr_i   = 48'h777;
        wif.out_ready_i = 1'b1;
        step();
        idle_inputs();
        vectors++;
        if (count !== 4'd7) begin
            $display("FAIL full_pop_count: got %0d want 7", count); miscompares++;
        end
        vectors++;
        if (wif.in_ready_o !== 1'b1) begin
            $display("FAIL full_pop_ready: got %b want 1", wif.in_ready_o); miscompares++;
        end
        wif.out_ready_i = 1'b1;
        for (int j = 1; j < 8; j++) begin
            vectors++;
            if (wif.out_addr_o !== 48'h100 + 48'(j)) begin
                $display("FAIL drain_order[%0d]: got %0h want %0h", j, wif.out_addr_o,
                         48'h100 + 48'(j)); miscompares++;
            end
            step();
        end
        wif.out_ready_i = 1'b0;
        vectors++;
        if (count !== 4'd0 || wif.out_valid_o !== 1'b0) begin
            $display("FAIL drain_empty: got count %0d valid %b want 0 0",
                     count, wif.out_valid_o); miscompares++;
        end
    endtask

    task automatic test_stream();
        // Pop request while empty must be ignored.
        wif.out_ready_i = 1'b1;
        wif.in_valid_i  = 1'b1;
        wif.in_addr_i   = 48'd0;
        step();
        vectors++;
        if (count !== 4'd1) begin
            $display("FAIL stream_first_count: got %0d want 1", count); miscompares++;
        end
        for (int i = 1; i < 20; i++) begin
            wif.in_addr_i = 48'(i);
            vectors++;
            if (wif.out_addr_o !== 48'(i - 1)) begin
                $display("FAIL stream_order[%0d]: got %0h want %0h", i, wif.out_addr_o,
                         48'(i - 1)); miscompares++;
            end
            step();
            vectors++;
            if (count !== 4'd1) begin
                $display("FAIL stream_count[%0d]: got %0d want 1", i, count); miscompares++;
            end
        end
        wif.in_valid_i = 1'b0;
        vectors++;
        if (wif.out_addr_o !== 48'd19) begin
            $display("FAIL stream_last: got %0h want 13", wif.out_addr_o); miscompares++;
        end
        step();
        idle_inputs();
        vectors++;
        if (count !== 4'd0) begin
            $display("FAIL stream_end_count: got %0d want 0", count); miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            wif.in_valid_i   = 1'b1;
            wif.in_bank_en_i = 4'b1111;
            wif.in_addr_i    = 48'h200 + 48'(i);
            wif.in_data_i    = 256'h55 + 256'(i);
            step();
        end
        // Attempted push during the reset cycle must be dropped.
        wif.in_addr_i = 48'hBAD;
        rst_p = 1'b1;
        step();
        rst_p = 1'b0;
        idle_inputs();
        vectors++;
        if (count !== 4'd0 || wif.out_valid_o !== 1'b0) begin
            $display("FAIL midreset_state: got count %0d valid %b want 0 0",
                     count, wif.out_valid_o); miscompares++;
        end
        vectors++;
        if (wif.out_data_o !== 256'd0 || wif.in_ready_o !== 1'b1 || afull !== 1'b0) begin
            $display("FAIL midreset_outputs: got data %0h ready %b afull %b want 0 1 0",
                     wif.out_data_o, wif.in_ready_o, afull); miscompares++;
        end
        wif.in_valid_i = 1'b1;
        wif.in_addr_i  = 48'h42;
        wif.in_data_i  = 256'h42;
        step();
        idle_inputs();
        vectors++;
        if (wif.out_addr_o !== 48'h42 || count !== 4'd1) begin
            $display("FAIL midreset_fresh: got addr %0h count %0d want 42 1",
                     wif.out_addr_o, count); miscompares++;
        end
        wif.out_ready_i = 1'b1;
        step();
        idle_inputs();
        vectors++;
        if (count !== 4'd0 || wif.out_valid_o !== 1'b0) begin
            $display("FAIL midreset_drain: got count %0d valid %b want 0 0",
                     count, wif.out_valid_o); miscompares++;
        end
    endtask

`ifdef WRITE_REQ_FIFO_STATS_EN
    task automatic test_stats();
        idle_inputs();
        rst_p = 1'b1;
        step();
        rst_p = 1'b0;
        vectors++;
        if (max_count !== 4'd0) begin
            $display("FAIL stats_reset: got %0d want 0", max_count); miscompares++;
        end
        for (int i = 0; i < 5; i++) begin
            wif.in_valid_i = 1'b1;
            wif.in_addr_i  = 48'(i);
            step();
        end
        idle_inputs();
        wif.out_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
        end
        idle_inputs();
        vectors++;
        if (count !== 4'd0 || max_count !== 4'd5) begin
            $display("FAIL stats_hwm: got count %0d max %0d want 0 5", count, max_count);
            miscompares++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_push();
        test_fill();
        test_full_pop();
        test_stream();
        test_reset_mid();
`ifdef WRITE_REQ_FIFO_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/write_req_fifo.md
WRITE_REQ_FIFO -- requirements
Module: write_req_fifo

Interface
REQ-001 SHALL have parameter ROW_PARA, default 4, bank-enable width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 48, request address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 256, request data width.
REQ-004 SHALL have parameter DEPTH, default 8, entry count; power of two, >=2.
REQ-005 SHALL have parameter AFULL_THRESH, default 6, almost-full level; range 1..DEPTH.
REQ-006 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port rst_p  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port in_valid_i  input  1  producer request valid.
REQ-009 SHALL have port in_bank_en_i  input  ROW_PARA  producer bank enables.
REQ-010 SHALL have port in_addr_i  input  ADDR_WIDTH  producer address.
REQ-011 SHALL have port in_data_i  input  DATA_WIDTH  producer data.
REQ-012 SHALL have port in_ready_o  output  1  FIFO can accept.
REQ-013 SHALL have port out_valid_o  output  1  head entry valid, toward write arbiter.
REQ-014 SHALL have port out_bank_en_o  output  ROW_PARA  head bank enables.
REQ-015 SHALL have port out_addr_o  output  ADDR_WIDTH  head address.
REQ-016 SHALL have port out_data_o  output  DATA_WIDTH  head data.
REQ-017 SHALL have port out_ready_i  input  1  arbiter grant for this requester.
REQ-018 SHALL have port count_o  output  $clog2(DEPTH)+1  current occupancy.
REQ-019 SHALL have port almost_full_o  output  1  count_o >= AFULL_THRESH.

Function
REQ-020 Push SHALL occur when in_valid_i && in_ready_o; pop SHALL occur when out_valid_o && out_ready_i.
REQ-021 in_ready_o SHALL be (count_o != DEPTH), from registered state only; no combinational path from out_ready_i.
REQ-022 When full, a push SHALL NOT occur even if a pop occurs in the same cycle.
REQ-023 Show-ahead: entry pushed in cycle N SHALL be presented on out_* in cycle N+1 when FIFO was empty.
REQ-024 out_valid_o SHALL be (count_o != 0).
REQ-025 When out_valid_o=0, out_bank_en_o, out_addr_o, out_data_o SHALL be all-zero (no spurious bank writes downstream).
REQ-026 Simultaneous push and pop when 0<count<DEPTH SHALL leave count_o unchanged; order preserved.
REQ-027 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap DEPTH-1 -> 0.
REQ-028 count_o SHALL be +1 on push-only, -1 on pop-only, unchanged otherwise; never exceeds DEPTH or underflows.
REQ-029 out_ready_i while out_valid_o=0 SHALL have no effect.

Reset
REQ-030 rst_p high SHALL clear pointers and count, giving in_ready_o=1, out_valid_o=0, out_* data=0, count_o=0, almost_full_o=0 the next cycle.
REQ-031 Reset mid-operation SHALL discard all stored entries; no push or pop in the reset cycle.

Configuration
REQ-032 With macro WRITE_REQ_FIFO_STATS_EN defined, SHALL add output max_count_o ($clog2(DEPTH)+1), high-water mark of count_o, reset to 0, updated when count_o exceeds it.
REQ-033 Without WRITE_REQ_FIFO_STATS_EN, max_count_o and its register SHALL be absent; all other behaviour identical.

Structure
REQ-034 Shared package SHALL hold the write-request field widths (ROW_PARA, ADDR_WIDTH, DATA_WIDTH defaults) and a packed write-request struct {bank_en, addr, data}.
REQ-035 Storage SHALL be one sub-module, wreq_ram (DEPTH x request width, synchronous write, asynchronous read); pointer/count control stays in write_req_fifo.

Verification
REQ-036 Reset then push addr=0x10, data=0xAA, bank_en=4'b0001, out_ready_i=0 -> next cycle out_valid_o=1, out_addr_o=0x10, count_o=1.
REQ-037 Push 8 entries, out_ready_i=0 -> count_o=8, in_ready_o=0, almost_full_o=1 from count 6; 9th in_valid_i not accepted.
REQ-038 Full FIFO, in_valid_i=1 and out_ready_i=1 same cycle -> pop only, count_o=7, in_ready_o=1 next cycle.
REQ-039 Continuous push/pop of 20 incrementing addresses with out_ready_i=1 -> outputs in order 0..19, pointers wrap, count_o stays 1.
REQ-040 Load 3 entries, assert rst_p one cycle -> count_o=0, out_valid_o=0, out_data_o=0; earlier entries never appear.
REQ-041 With WRITE_REQ_FIFO_STATS_EN: fill to 5, drain to 0 -> max_count_o=5; without the macro, build succeeds with no max_count_o port.
